// File: rtl/addsub_div_ctrl.sv
// Multi-cycle restoring divider: one shared add/sub datapath, one trial subtract
// and one restore-or-keep step per quotient bit.
module addsub_div_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StSub, StFix, StDone} state_e;

  state_e           state_q;
  logic [WIDTH:0]   r_q, t_q;
  logic [WIDTH-1:0] q_q, d_q;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q, done_q, dz_q;
  logic [WIDTH-1:0] quo_q, rem_q;

  logic             sub;
  logic [WIDTH:0]   r_shift, add_a, add_b, add_sum;
  logic             unused_r_msb;

  // Single adder: subtract in SUB (inverted operand + carry-in), restore-add in FIX.
  always_comb begin
    sub     = (state_q == StSub);
    r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    add_a   = sub ? r_shift : t_q;
    add_b   = {1'b0, d_q} ^ {(WIDTH + 1){sub}};
    add_sum = add_a + add_b + (WIDTH + 1)'(sub);
  end

  assign unused_r_msb = r_q[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      r_q     <= '0;
      t_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (divisor != '0) begin
              r_q     <= '0;
              q_q     <= dividend;
              d_q     <= divisor;
              cnt_q   <= '0;
              dz_q    <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= StSub;
            end else begin
              quo_q   <= '1;
              rem_q   <= dividend;
              dz_q    <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StSub: begin
          t_q     <= add_sum;
          r_q     <= r_shift;
          q_q     <= {q_q[WIDTH-2:0], 1'b0};
          state_q <= StFix;
        end
        StFix: begin
          if (t_q[WIDTH]) begin
            r_q    <= add_sum;
            q_q[0] <= 1'b0;
          end else begin
            r_q    <= t_q;
            q_q[0] <= 1'b1;
          end
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            busy_q  <= 1'b0;
            state_q <= StDone;
          end else begin
            state_q <= StSub;
          end
        end
        StDone: begin
          done_q <= 1'b1;
          // Divide-by-zero results were already loaded when the request was taken.
          if (!dz_q) begin
            quo_q <= q_q;
            rem_q <= r_q[WIDTH-1:0];
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_addsub_div_ctrl.sv
// Self-checking bench for addsub_div_ctrl (WIDTH=4) against a plain a/b, a%b model.
module tb_addsub_div_ctrl;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [3:0] dividend, divisor;
  logic       busy, done, div_by_zero;
  logic [3:0] quotient, remainder;

  int tests = 0;
  int fails = 0;

  addsub_div_ctrl #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] ref_q(input logic [3:0] a, input logic [3:0] b);
    return (b == 0) ? 4'hF : 4'(int'(a) / int'(b));
  endfunction

  function automatic logic [3:0] ref_r(input logic [3:0] a, input logic [3:0] b);
    return (b == 0) ? a : 4'(int'(a) % int'(b));
  endfunction

  function automatic int ref_lat(input logic [3:0] b);
    return (b == 0) ? 1 : 9;
  endfunction

  // Issue one job and observe it until one cycle past its done pulse (bounded).
  task automatic run_div(input logic [3:0] a, input logic [3:0] b, output int lat,
                         output int busy_cnt, output int done_cnt, output logic [3:0] q,
                         output logic [3:0] r, output logic dz);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 4'($urandom);
    divisor  = 4'($urandom);
    lat      = -1;
    busy_cnt = int'(busy);
    done_cnt = 0;
    q = 'x;
    r = 'x;
    dz = 1'bx;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      busy_cnt += int'(busy);
      done_cnt += int'(done);
      if (done && lat < 0) begin
        lat = n;
        q   = quotient;
        r   = remainder;
        dz  = div_by_zero;
      end
      if (lat >= 0 && n == lat + 1) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    dividend = 4'd0;
    divisor = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({busy, done, div_by_zero, quotient, remainder} !== 11'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %b, expected all zero",
               {busy, done, div_by_zero, quotient, remainder});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat, bc, dc;
    logic [3:0] q, r;
    logic dz;
    run_div(4'd13, 4'd3, lat, bc, dc, q, r, dz);
    tests++;
    if (lat !== 9) begin fails++; $display("FAIL basic_latency: got %0d, expected 9", lat); end
    tests++;
    if (bc !== 8) begin fails++; $display("FAIL basic_busy_cycles: got %0d, expected 8", bc); end
    tests++;
    if (dc !== 1) begin fails++; $display("FAIL basic_done_width: got %0d, expected 1", dc); end
    tests++;
    if ({q, r, dz} !== {4'd4, 4'd1, 1'b0}) begin
      fails++;
      $display("FAIL basic_result: got q=%0d r=%0d dz=%b, expected q=4 r=1 dz=0", q, r, dz);
    end
  endtask

  task automatic test_sweep();
    logic [3:0] as [4] = '{4'd15, 4'd15, 4'd7, 4'd0};
    logic [3:0] bs [4] = '{4'd1, 4'd15, 4'd9, 4'd5};
    logic [3:0] eq [4] = '{4'd15, 4'd1, 4'd0, 4'd0};
    logic [3:0] er [4] = '{4'd0, 4'd0, 4'd7, 4'd0};
    int lat, bc, dc;
    logic [3:0] q, r;
    logic dz;
    for (int i = 0; i < 4; i++) begin
      run_div(as[i], bs[i], lat, bc, dc, q, r, dz);
      tests++;
      if ({q, r, dz} !== {eq[i], er[i], 1'b0} || lat !== 9) begin
        fails++;
        $display("FAIL sweep_%0d/%0d: got q=%0d r=%0d dz=%b lat=%0d, expected q=%0d r=%0d dz=0 lat=9",
                 as[i], bs[i], q, r, dz, lat, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat, bc, dc;
    logic [3:0] q, r;
    logic dz;
    run_div(4'd6, 4'd0, lat, bc, dc, q, r, dz);
    tests++;
    if (lat !== 1 || bc !== 0 || dc !== 1) begin
      fails++;
      $display("FAIL div0_timing: got lat=%0d busy=%0d done=%0d, expected lat=1 busy=0 done=1",
               lat, bc, dc);
    end
    tests++;
    if ({q, r, dz} !== {4'd15, 4'd6, 1'b1}) begin
      fails++;
      $display("FAIL div0_result: got q=%0d r=%0d dz=%b, expected q=15 r=6 dz=1", q, r, dz);
    end
  endtask

  task automatic test_ignore_start();
    int lat = -1;
    int bc, dc = 0;
    logic [3:0] q = 'x, r = 'x;
    @(negedge clk);
    dividend = 4'd13;
    divisor  = 4'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    bc = int'(busy);
    for (int n = 1; n <= 22; n++) begin
      @(posedge clk);
      #1;
      bc += int'(busy);
      dc += int'(done);
      if (done && lat < 0) begin
        lat = n;
        q = quotient;
        r = remainder;
      end
      start = (n == 3 || n == 8);
      dividend = 4'd2;
      divisor  = 4'd1;
    end
    start = 1'b0;
    tests++;
    if (lat !== 9 || dc !== 1 || bc !== 8) begin
      fails++;
      $display("FAIL ignore_start_timing: got lat=%0d done=%0d busy=%0d, expected 9/1/8",
               lat, dc, bc);
    end
    tests++;
    if ({q, r} !== {4'd4, 4'd1}) begin
      fails++;
      $display("FAIL ignore_start_result: got q=%0d r=%0d, expected q=4 r=1", q, r);
    end
  endtask

  task automatic test_rst_mid();
    int dc = 0;
    int lat, bc, dc2;
    logic [3:0] q, r;
    logic dz;
    @(negedge clk);
    dividend = 4'd13;
    divisor  = 4'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tests++;
    if ({busy, done, div_by_zero, quotient, remainder} !== 11'd0) begin
      fails++;
      $display("FAIL rst_mid_outputs: got %b, expected all zero",
               {busy, done, div_by_zero, quotient, remainder});
    end
    repeat (15) begin
      @(posedge clk);
      #1;
      dc += int'(done) + int'(busy);
    end
    tests++;
    if (dc !== 0) begin fails++; $display("FAIL rst_mid_no_done: got %0d, expected 0", dc); end
    run_div(4'd9, 4'd2, lat, bc, dc2, q, r, dz);
    tests++;
    if ({q, r, dz} !== {4'd4, 4'd1, 1'b0} || lat !== 9) begin
      fails++;
      $display("FAIL rst_mid_rerun: got q=%0d r=%0d dz=%b lat=%0d, expected q=4 r=1 dz=0 lat=9",
               q, r, dz, lat);
    end
  endtask

  task automatic test_rst_start_same();
    int act = 0;
    @(negedge clk);
    dividend = 4'd13;
    divisor  = 4'd3;
    start    = 1'b1;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    rst   = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      act += int'(busy) + int'(done);
    end
    tests++;
    if (act !== 0) begin
      fails++;
      $display("FAIL rst_start_same: got %0d active cycles, expected 0", act);
    end
  endtask

  task automatic test_random();
    int lat, bc, dc;
    logic [3:0] a, b, q, r;
    logic dz;
    for (int i = 0; i < 40; i++) begin
      a = 4'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_div(a, b, lat, bc, dc, q, r, dz);
      tests++;
      if ({q, r, dz} !== {ref_q(a, b), ref_r(a, b), b == 0} || lat !== ref_lat(b) || dc !== 1) begin
        fails++;
        $display("FAIL random_%0d/%0d: got q=%0d r=%0d dz=%b lat=%0d, expected q=%0d r=%0d lat=%0d",
                 a, b, q, r, dz, lat, ref_q(a, b), ref_r(a, b), ref_lat(b));
      end
    end
  endtask

  task automatic test_exhaustive();
    int lat, bc, dc;
    logic [3:0] a, b, q, r;
    logic dz;
    for (int i = 0; i < 256; i++) begin
      a = 4'(i >> 4);
      b = 4'(i);
      run_div(a, b, lat, bc, dc, q, r, dz);
      tests++;
      if ({q, r, dz} !== {ref_q(a, b), ref_r(a, b), b == 0} || lat !== ref_lat(b) || dc !== 1
          || bc !== ((b == 0) ? 0 : 8)) begin
        fails++;
        $display("FAIL exh_%0d/%0d: got q=%0d r=%0d dz=%b lat=%0d done=%0d busy=%0d, expected q=%0d r=%0d lat=%0d",
                 a, b, q, r, dz, lat, dc, bc, ref_q(a, b), ref_r(a, b), ref_lat(b));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sweep();
    test_div_zero();
    test_ignore_start();
    test_rst_mid();
    test_rst_start_same();
    test_random();
    test_exhaustive();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
